// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall, flush and invalid-slot bubble insertion.
// Optional performance counters are compiled in with `define ID_EX_PERF_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
`ifdef ID_EX_PERF_EN
    ,
    parameter int COUNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic               ValidD,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic               BranchD,
    input  logic               ALUSrcD,
    input  logic               RegDstD,
    input  logic [2:0]         ALUControlD,
    input  logic [DATA_W-1:0]  RD1D,
    input  logic [DATA_W-1:0]  RD2D,
    input  logic [DATA_W-1:0]  SignImmD,
    input  logic [DATA_W-1:0]  PCPlus4D,
    input  logic [REG_W-1:0]   RsD,
    input  logic [REG_W-1:0]   RtD,
    input  logic [REG_W-1:0]   RdD,
`ifdef ID_EX_PERF_EN
    output logic [COUNT_W-1:0] BubbleCountE,
    output logic [COUNT_W-1:0] StallCountE,
`endif
    output logic               ValidE,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               MemWriteE,
    output logic               BranchE,
    output logic               ALUSrcE,
    output logic               RegDstE,
    output logic [2:0]         ALUControlE,
    output logic [DATA_W-1:0]  RD1E,
    output logic [DATA_W-1:0]  RD2E,
    output logic [DATA_W-1:0]  SignImmE,
    output logic [DATA_W-1:0]  PCPlus4E,
    output logic [REG_W-1:0]   RsE,
    output logic [REG_W-1:0]   RtE,
    output logic [REG_W-1:0]   RdE
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              memto_reg;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic              reg_dst;
        logic [2:0]        alu_control;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sign_imm;
        logic [DATA_W-1:0] pc_plus4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } slot_t;

    slot_t r_e;
    slot_t w_d;
    logic  w_bubble;

    // Flush overrides stall; an illegal decode slot becomes a bubble only when not stalled.
    assign w_bubble = FlushE | (~StallE & ~ValidD);

    assign w_d = '{
        valid:       1'b1,
        reg_write:   RegWriteD,
        memto_reg:   MemtoRegD,
        mem_write:   MemWriteD,
        branch:      BranchD,
        alu_src:     ALUSrcD,
        reg_dst:     RegDstD,
        alu_control: ALUControlD,
        rd1:         RD1D,
        rd2:         RD2D,
        sign_imm:    SignImmD,
        pc_plus4:    PCPlus4D,
        rs:          RsD,
        rt:          RtD,
        rd:          RdD
    };

    // NOTE: the bubble loads the constant '0 rather than masking w_d, so X on the
    // control inputs of an invalid slot cannot leak through the register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flop state; blocking here would race
        // against readers of r_e sampled on the same edge.
        if (reset || w_bubble) begin
            r_e <= '0;
        end else if (!StallE) begin
            r_e <= w_d;
        end
    end

    assign ValidE      = r_e.valid;
    assign RegWriteE   = r_e.reg_write;
    assign MemtoRegE   = r_e.memto_reg;
    assign MemWriteE   = r_e.mem_write;
    assign BranchE     = r_e.branch;
    assign ALUSrcE     = r_e.alu_src;
    assign RegDstE     = r_e.reg_dst;
    assign ALUControlE = r_e.alu_control;
    assign RD1E        = r_e.rd1;
    assign RD2E        = r_e.rd2;
    assign SignImmE    = r_e.sign_imm;
    assign PCPlus4E    = r_e.pc_plus4;
    assign RsE         = r_e.rs;
    assign RtE         = r_e.rt;
    assign RdE         = r_e.rd;

`ifdef ID_EX_PERF_EN
    logic [COUNT_W-1:0] r_bubble_cnt;
    logic [COUNT_W-1:0] r_stall_cnt;
    logic               w_stall_edge;

    assign w_stall_edge = StallE & ~FlushE;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + COUNT_W'(1);
            end
            if (w_stall_edge && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
            end
        end
    end

    assign BubbleCountE = r_bubble_cnt;
    assign StallCountE  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected slots are queued when stimulus is
// applied and compared one edge later. Counter tests compile in with ID_EX_PERF_EN.
module tb_id_ex_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int COUNT_W = 4;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              memto_reg;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic              reg_dst;
        logic [2:0]        alu_control;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sign_imm;
        logic [DATA_W-1:0] pc_plus4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } slot_t;

    logic              clk = 1'b0;
    logic              reset, StallE, FlushE, ValidD;
    logic              RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD;
    logic [2:0]        ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
    logic [REG_W-1:0]  RsD, RtD, RdD;
    logic              ValidE;
    logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, SignImmE, PCPlus4E;
    logic [REG_W-1:0]  RsE, RtE, RdE;
`ifdef ID_EX_PERF_EN
    logic [COUNT_W-1:0] BubbleCountE, StallCountE;
`endif

    int    checks   = 0;
    int    failures = 0;
    slot_t sb_q[$];
    slot_t model    = '0;
    slot_t exp_s;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W(DATA_W),
        .REG_W(REG_W)
`ifdef ID_EX_PERF_EN
        ,
        .COUNT_W(COUNT_W)
`endif
    ) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
`ifdef ID_EX_PERF_EN
        .BubbleCountE(BubbleCountE), .StallCountE(StallCountE),
`endif
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .PCPlus4E(PCPlus4E), .RsE(RsE), .RtE(RtE), .RdE(RdE)
    );

    function automatic slot_t observed();
        return '{ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE,
                 ALUControlE, RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE};
    endfunction

    task automatic set_word(input logic [6:0] ctrl, input logic [2:0] alu,
                            input logic [DATA_W-1:0] rd1, rd2, imm, pc,
                            input logic [REG_W-1:0] rs, rt, rd);
        {RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD} = ctrl[5:0];
        ValidD      = ctrl[6];
        ALUControlD = alu;
        RD1D = rd1; RD2D = rd2; SignImmD = imm; PCPlus4D = pc;
        RsD = rs; RtD = rt; RdD = rd;
    endtask

    task automatic random_word(input logic valid);
        set_word({valid, 6'($urandom)}, 3'($urandom), $urandom, $urandom, $urandom,
                 $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    endtask

    // Reference next-state from the priority list; push the expectation, then clock.
    task automatic apply();
        slot_t nxt;
        if (reset || FlushE)  nxt = '0;
        else if (StallE)      nxt = model;
        else if (!ValidD)     nxt = '0;
        else nxt = '{1'b1, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD,
                     ALUControlD, RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD};
        model = nxt;
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_word(7'h7F, 3'b111, 32'hDEADBEEF, 32'hCAFEF00D, 32'h1234, 32'h400, 5'd1, 5'd2, 5'd3);
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply();
            exp_s = sb_q.pop_front();
            checks++;
            if (observed() !== exp_s || observed() !== slot_t'(0)) begin
                failures++;
                $display("FAIL reset_%0d got=%h exp=%h", i, observed(), exp_s);
            end
        end
        reset = 1'b0;
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || RD1E !== 32'hDEADBEEF || ValidE !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", observed(), exp_s);
        end
    endtask

    task automatic test_pass_through();
        set_word(7'b1_100001, 3'b110, 32'd7, 32'd3, 32'h0, 32'h104, 5'd4, 5'd5, 5'd8);
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || ALUControlE !== 3'b110 || RdE !== 5'd8 || RD2E !== 32'd3) begin
            failures++;
            $display("FAIL pass_through got=%h exp=%h", observed(), exp_s);
        end
    endtask

    task automatic test_stall();
        slot_t lw;
        set_word(7'b1_010010, 3'b010, 32'h100, 32'h0, 32'h4, 32'h108, 5'd9, 5'd10, 5'd0);
        apply();
        lw = sb_q.pop_front();
        checks++;
        if (observed() !== lw) begin
            failures++;
            $display("FAIL stall_load got=%h exp=%h", observed(), lw);
        end
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            random_word(1'b1);
            apply();
            exp_s = sb_q.pop_front();
            checks++;
            if (observed() !== exp_s || observed() !== lw) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", i, observed(), lw);
            end
        end
        StallE = 1'b0;
        set_word(7'b1_000001, 3'b001, 32'h55, 32'hAA, 32'h8, 32'h10C, 5'd11, 5'd12, 5'd13);
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || RD1E !== 32'h55) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", observed(), exp_s);
        end
    endtask

    task automatic test_flush_over_stall();
        set_word(7'b1_001010, 3'b010, 32'h200, 32'h77, 32'hC, 32'h110, 5'd14, 5'd15, 5'd0);
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || MemWriteE !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre_sw got=%h exp=%h", observed(), exp_s);
        end
        StallE = 1'b1; FlushE = 1'b1;
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || MemWriteE !== 1'b0 || ValidE !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall got=%h exp=%h", observed(), exp_s);
        end
        StallE = 1'b0; FlushE = 1'b0;
    endtask

    task automatic test_invalid_decode();
        random_word(1'b1);
        apply();
        void'(sb_q.pop_front());
        ValidD = 1'b0;
        {RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD} = 'x;
        ALUControlD = 'x;
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || $isunknown(observed())) begin
            failures++;
            $display("FAIL invalid_decode got=%h exp=%h", observed(), exp_s);
        end
    endtask

    task automatic test_reset_mid_stall_flush();
        random_word(1'b1);
        apply();
        void'(sb_q.pop_front());
        StallE = 1'b1; reset = 1'b1;
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s) begin
            failures++;
            $display("FAIL reset_mid_stall got=%h exp=%h", observed(), exp_s);
        end
        StallE = 1'b0; FlushE = 1'b1;
        apply();
        void'(sb_q.pop_front());
        reset = 1'b0; FlushE = 1'b0;
        random_word(1'b1);
        apply();
        exp_s = sb_q.pop_front();
        checks++;
        if (observed() !== exp_s || ValidE !== 1'b1) begin
            failures++;
            $display("FAIL reset_resume got=%h exp=%h", observed(), exp_s);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            random_word(($urandom_range(0, 3) != 0));
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 5) == 0);
            apply();
            exp_s = sb_q.pop_front();
            checks++;
            if (observed() !== exp_s) begin
                failures++;
                $display("FAIL back_to_back_%0d got=%h exp=%h", i, observed(), exp_s);
            end
        end
        StallE = 1'b0; FlushE = 1'b0;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        apply();
        void'(sb_q.pop_front());
        reset = 1'b0; StallE = 1'b1;
        random_word(1'b1);
        for (int i = 0; i < 5; i++) begin
            apply();
            void'(sb_q.pop_front());
        end
        checks++;
        if (StallCountE !== 4'd5 || BubbleCountE !== 4'd0) begin
            failures++;
            $display("FAIL perf_stall got=%0d/%0d exp=5/0", StallCountE, BubbleCountE);
        end
        FlushE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply();
            void'(sb_q.pop_front());
        end
        checks++;
        if (BubbleCountE !== 4'hF || StallCountE !== 4'd5) begin
            failures++;
            $display("FAIL perf_saturate got=%h/%h exp=f/5", BubbleCountE, StallCountE);
        end
        FlushE = 1'b0; StallE = 1'b0; reset = 1'b1;
        apply();
        void'(sb_q.pop_front());
        checks++;
        if (BubbleCountE !== 4'd0 || StallCountE !== 4'd0) begin
            failures++;
            $display("FAIL perf_reset got=%h/%h exp=0/0", BubbleCountE, StallCountE);
        end
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        random_word(1'b0);
        test_reset();
        test_pass_through();
        test_stall();
        test_flush_over_stall();
        test_invalid_decode();
        test_reset_mid_stall_flush();
        test_back_to_back();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
